// File: rtl/wb_framebuffer_slave.sv
// Wishbone framebuffer slave: DEPTH x 32-bit words of packed 3-bit pixels, 1-cycle write / 2-cycle read ack.
// Optional whole-buffer clear engine is built only when FB_CLEAR_EN is defined.
module wb_framebuffer_slave #(
    parameter int DEPTH = 60000,
    parameter int AW    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fb_adr_i,
    input  logic [31:0] fb_dat_i,
    output logic [31:0] fb_dat_o,
    input  logic        fb_cyc_i,
    input  logic        fb_stb_i,
    input  logic        fb_we_i,
    input  logic [3:0]  fb_sel_i,
    output logic        fb_ack_o,
    input  logic [31:0] base_address,
    input  logic        clear_start,
    input  logic [2:0]  clear_color,
    output logic        clear_busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        ACK  = 3'd2,
        HOLD = 3'd3
`ifdef FB_CLEAR_EN
        , CLEAR = 3'd4
`endif
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t state_reg, state_next;

    logic [31:0] offset;
    logic [31:0] word_idx;
    logic        in_range;
    logic [AW-1:0] bus_idx;
    logic        bus_req;
    logic        clear_go;
    logic        accept;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;

    logic [31:0] mem [DEPTH];
    logic [31:0] ram_q;
    logic        rd_ok_reg;

    // Unsigned subtract: addresses below base wrap to a huge index and fall out of range.
    assign offset   = fb_adr_i - base_address;
    assign word_idx = {2'b00, offset[31:2]};
    assign in_range = (word_idx < DEPTH_W);
    assign bus_idx  = offset[AW+1:2];
    assign bus_req  = fb_cyc_i & fb_stb_i;
    assign accept   = (state_reg == IDLE) && bus_req && !clear_go;

`ifdef FB_CLEAR_EN
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [AW-1:0] clr_cnt_reg;
    logic          clr_pend_reg;
    logic [2:0]    clr_color_reg;
    logic [31:0]   fill_word;
    logic          unused_lsb;

    assign clear_go   = clear_start | clr_pend_reg;
    assign unused_lsb = ^offset[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_fill
            assign fill_word[4*gi +: 4] = {1'b0, clr_color_reg};
        end
    endgenerate

    // A request arriving while a bus cycle is in flight is remembered and runs on the next IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_cnt_reg   <= '0;
            clr_pend_reg  <= 1'b0;
            clr_color_reg <= 3'd0;
        end else begin
            if (state_reg == CLEAR)
                clr_cnt_reg <= (clr_cnt_reg == LAST_IDX) ? '0 : clr_cnt_reg + 1'b1;
            if (state_reg == IDLE)
                clr_pend_reg <= 1'b0;
            else if (state_reg != CLEAR && clear_start)
                clr_pend_reg <= 1'b1;
            if (state_reg != CLEAR && clear_start && !clr_pend_reg)
                clr_color_reg <= clear_color;
        end
    end
`else
    logic unused_inputs;

    assign clear_go      = 1'b0;
    assign unused_inputs = ^{clear_start, clear_color, offset[1:0]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
`ifdef FB_CLEAR_EN
                if (clear_go)
                    state_next = CLEAR;
                else
`endif
                if (bus_req)
                    state_next = fb_we_i ? ACK : READ;
            end
            READ:    state_next = fb_cyc_i ? ACK : IDLE;
            ACK:     state_next = HOLD;
            HOLD:    if (!fb_stb_i || !fb_cyc_i) state_next = IDLE;
`ifdef FB_CLEAR_EN
            CLEAR:   if (clr_cnt_reg == LAST_IDX) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fb_ack_o = (state_reg == ACK);
`ifdef FB_CLEAR_EN
        clear_busy = (state_reg == CLEAR);
`else
        clear_busy = 1'b0;
`endif
    end

    // Single RAM write port shared by the bus and the clear engine.
    always_comb begin
        wr_en   = accept && fb_we_i && in_range;
        wr_addr = bus_idx;
        wr_data = fb_dat_i;
        wr_be   = fb_sel_i;
`ifdef FB_CLEAR_EN
        if (state_reg == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt_reg;
            wr_data = fill_word;
            wr_be   = 4'hF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b])
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        if (accept && !fb_we_i && in_range)
            ram_q <= mem[bus_idx];
    end

    // Read data is committed only when entering ACK, so it holds everywhere else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fb_dat_o  <= '0;
            rd_ok_reg <= 1'b0;
        end else begin
            if (accept)
                rd_ok_reg <= in_range;
            if (accept && fb_we_i && !in_range)
                fb_dat_o <= '0;
            else if (state_reg == READ && fb_cyc_i)
                fb_dat_o <= rd_ok_reg ? ram_q : '0;
        end
    end

endmodule

// File: tb/tb_wb_framebuffer_slave.sv
// Directed testbench for wb_framebuffer_slave; clear-engine steps run only when FB_CLEAR_EN is defined.
module tb_wb_framebuffer_slave;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int LIMIT = 4 * DEPTH + 100;

    logic        clk;
    logic        rst;
    logic [31:0] fb_adr_i;
    logic [31:0] fb_dat_i;
    logic [31:0] fb_dat_o;
    logic        fb_cyc_i;
    logic        fb_stb_i;
    logic        fb_we_i;
    logic [3:0]  fb_sel_i;
    logic        fb_ack_o;
    logic [31:0] base_address;
    logic        clear_start;
    logic [2:0]  clear_color;
    logic        clear_busy;

    int total = 0;
    int passed = 0;
    int ack_count = 0;

    wb_framebuffer_slave #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .fb_adr_i     (fb_adr_i),
        .fb_dat_i     (fb_dat_i),
        .fb_dat_o     (fb_dat_o),
        .fb_cyc_i     (fb_cyc_i),
        .fb_stb_i     (fb_stb_i),
        .fb_we_i      (fb_we_i),
        .fb_sel_i     (fb_sel_i),
        .fb_ack_o     (fb_ack_o),
        .base_address (base_address),
        .clear_start  (clear_start),
        .clear_color  (clear_color),
        .clear_busy   (clear_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (fb_ack_o) ack_count <= ack_count + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=still running required=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // One Wishbone transfer; stb stays high 'hold' extra cycles after ack is seen.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int hold,
                        output logic [31:0] rdat, output int lat);
        @(negedge clk);
        fb_cyc_i = 1'b1; fb_stb_i = 1'b1; fb_we_i = we;
        fb_adr_i = adr; fb_dat_i = dat; fb_sel_i = sel;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!fb_ack_o && lat < LIMIT);
        rdat = fb_dat_o;
        repeat (hold) @(posedge clk);
        #1;
        fb_cyc_i = 1'b0; fb_stb_i = 1'b0; fb_we_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] rdat;
        int lat;
        xfer(1'b1, adr, dat, sel, 0, rdat, lat);
        check({tag, "_lat"}, 32'(lat), 32'd1);
    endtask

    task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rdat;
        int lat;
        xfer(1'b0, adr, 32'h0, 4'hF, 0, rdat, lat);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_dat"}, rdat, exp);
    endtask

    initial begin
        logic [31:0] rdat;
        int lat;
        int a;
        int n;

        rst = 1'b0; fb_adr_i = '0; fb_dat_i = '0; fb_cyc_i = 1'b0; fb_stb_i = 1'b0;
        fb_we_i = 1'b0; fb_sel_i = 4'h0; base_address = BASE; clear_start = 1'b0; clear_color = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, fb_ack_o}, 32'd0);
        check("rst_dat", fb_dat_o, 32'd0);
        check("rst_busy", {31'd0, clear_busy}, 32'd0);
        @(negedge clk); rst = 1'b1;

        wr("w_basic", BASE + 32'd4, 32'h7654_3210, 4'hF);
        rd("r_basic", BASE + 32'd4, 32'h7654_3210);

        wr("w_zero", BASE + 32'd8, 32'h0, 4'hF);
        wr("w_sel0101", BASE + 32'd8, 32'hFFFF_FFFF, 4'b0101);
        rd("r_sel0101", BASE + 32'd8, 32'h00FF_00FF);

        wr("w_zero2", BASE + 32'd12, 32'h0, 4'hF);
        wr("w_sel1000", BASE + 32'd12, 32'h1122_3344, 4'b1000);
        rd("r_sel1000", BASE + 32'd12, 32'h1100_0000);

        wr("w_last", BASE + 32'(4 * (DEPTH - 1)), 32'hA5A5_5A5A, 4'hF);
        rd("r_oor", BASE + 32'(4 * DEPTH), 32'h0);
        rd("r_last_a", BASE + 32'(4 * (DEPTH - 1)), 32'hA5A5_5A5A);
        xfer(1'b1, BASE + 32'(4 * DEPTH), 32'hDEAD_BEEF, 4'hF, 0, rdat, lat);
        check("w_oor_lat", 32'(lat), 32'd1);
        check("w_oor_dat", rdat, 32'h0);
        rd("r_last_b", BASE + 32'(4 * (DEPTH - 1)), 32'hA5A5_5A5A);
        rd("r_below", BASE - 32'd4, 32'h0);

        a = ack_count;
        xfer(1'b1, BASE + 32'd16, 32'h0BAD_F00D, 4'hF, 3, rdat, lat);
        check("hold_lat", 32'(lat), 32'd1);
        check("hold_acks", 32'(ack_count - a), 32'd1);
        rd("r_hold", BASE + 32'd16, 32'h0BAD_F00D);

        repeat (4) @(posedge clk);
        #1;
        check("dat_hold_idle", fb_dat_o, 32'h0BAD_F00D);
        wr("w_keep", BASE + 32'd20, 32'h0000_0001, 4'hF);
        check("dat_hold_wr", fb_dat_o, 32'h0BAD_F00D);

        a = ack_count;
        @(negedge clk);
        fb_cyc_i = 1'b1; fb_stb_i = 1'b1; fb_we_i = 1'b0; fb_adr_i = BASE + 32'd4;
        @(posedge clk); #1;
        fb_cyc_i = 1'b0; fb_stb_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_acks", 32'(ack_count - a), 32'd0);
        check("abort_dat", fb_dat_o, 32'h0BAD_F00D);
        rd("r_after_abort", BASE + 32'd4, 32'h7654_3210);

`ifdef FB_CLEAR_EN
        // Clear and a read request arrive together: clear first, then the held read.
        @(negedge clk);
        clear_color = 3'b101; clear_start = 1'b1;
        fb_cyc_i = 1'b1; fb_stb_i = 1'b1; fb_we_i = 1'b0; fb_adr_i = BASE + 32'd28;
        @(posedge clk); #1;
        clear_start = 1'b0;
        check("clr_busy_start", {31'd0, clear_busy}, 32'd1);
        a = ack_count;
        n = 1;
        while (clear_busy && n < LIMIT) begin
            if (n == 50) begin
                clear_color = 3'b011; clear_start = 1'b1;
            end else begin
                clear_start = 1'b0;
            end
            @(posedge clk); #1;
            if (clear_busy) n++;
        end
        clear_start = 1'b0;
        check("clr_cycles", 32'(n), 32'(DEPTH));
        check("clr_no_ack", 32'(ack_count - a), 32'd0);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!fb_ack_o && lat < LIMIT);
        check("clr_pend_rd_lat", 32'(lat), 32'd2);
        check("clr_pend_rd_dat", fb_dat_o, 32'h5555_5555);
        fb_cyc_i = 1'b0; fb_stb_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rd("r_clr_first", BASE, 32'h5555_5555);
        rd("r_clr_last", BASE + 32'(4 * (DEPTH - 1)), 32'h5555_5555);

        // Clear requested mid-read is deferred until the bus cycle finishes.
        @(negedge clk);
        fb_cyc_i = 1'b1; fb_stb_i = 1'b1; fb_we_i = 1'b0; fb_adr_i = BASE + 32'd12;
        @(posedge clk); #1;
        clear_color = 3'b010; clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        check("pend_ack", {31'd0, fb_ack_o}, 32'd1);
        check("pend_dat", fb_dat_o, 32'h5555_5555);
        fb_cyc_i = 1'b0; fb_stb_i = 1'b0;
        n = 0;
        while (!clear_busy && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("pend_clr_delay", 32'(n), 32'd3);
        n = 0;
        while (clear_busy && n < LIMIT) begin
            @(posedge clk); #1; n++;
        end
        rd("r_pend_clr", BASE + 32'd12, 32'h2222_2222);

        // Reset partway through a clear: words from index 100 upward keep old data.
        @(negedge clk);
        clear_color = 3'b111; clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        check("rclr_busy", {31'd0, clear_busy}, 32'd1);
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rclr_busy_rst", {31'd0, clear_busy}, 32'd0);
        check("rclr_dat_rst", fb_dat_o, 32'h0);
        @(negedge clk); rst = 1'b1;
        rd("r_rclr_99", BASE + 32'(4 * 99), 32'h7777_7777);
        rd("r_rclr_100", BASE + 32'(4 * 100), 32'h2222_2222);
        rd("r_rclr_last", BASE + 32'(4 * (DEPTH - 1)), 32'h2222_2222);
`else
        @(negedge clk);
        clear_color = 3'b101; clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        check("noclr_busy_a", {31'd0, clear_busy}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("noclr_busy_b", {31'd0, clear_busy}, 32'd0);
        rd("r_noclr", BASE + 32'd4, 32'h7654_3210);
        rd("r_noclr_last", BASE + 32'(4 * (DEPTH - 1)), 32'hA5A5_5A5A);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
